// File: rtl/cache_ctrl_pkg.sv
// Address-field widths and FSM state encoding shared by the L1 data-cache controller.
package cache_ctrl_pkg;

    localparam int DEF_ADDR_BITS       = 32;
    localparam int DEF_TAG_BITS        = 23;
    localparam int DEF_LINE_WORDS      = 4;
    localparam int SET_INDEX_WIDTH     = 5;
    localparam int ELEMENT_WORDS_WIDTH = 2;
    localparam int WORD_BYTES_WIDTH    = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        BACK_RD = 3'd2,
        BACK_WR = 3'd3,
        FILL    = 3'd4,
        REPLAY  = 3'd5
    } state_t;

endpackage

// File: rtl/cache_ctrl.sv
// Miss handling for the 2-way L1 data cache: hit check, dirty-victim writeback,
// line fill from main memory one word per ack, then replay of the CPU request.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [ADDR_BITS-1:0] addr_cpu,
    input  logic [31:0]          data_cpu_write,
    output logic [31:0]          data_cpu_read,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int BEAT_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = BEAT_BITS + WORD_BYTES_WIDTH;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [BEAT_BITS-1:0]   r_beat;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [31:0]            r_data;
    logic [2:0]             r_ubhw;
    logic                   r_isWrite;
    logic [TAG_BITS-1:0]    r_victimTag;
    logic [31:0]            r_wbData;
    logic                   r_wbLatched;

    logic                   w_req;
    logic [ADDR_BITS-1:0]   w_lineAddr;
    logic [ADDR_BITS-1:0]   w_victimAddr;

    // A request is never accepted while reset is held, so every output stays low.
    assign w_req        = (en_r | en_w) & ~rst;
    assign w_lineAddr   = {r_addr[ADDR_BITS-1:OFFSET_BITS], r_beat, {WORD_BYTES_WIDTH{1'b0}}};
    assign w_victimAddr = {r_victimTag, r_addr[ADDR_BITS-TAG_BITS-1:OFFSET_BITS], r_beat,
                           {WORD_BYTES_WIDTH{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_ubhw      <= '0;
            r_isWrite   <= 1'b0;
            r_victimTag <= '0;
            r_wbData    <= '0;
            r_wbLatched <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr    <= addr_cpu;
                        r_data    <= data_cpu_write;
                        r_ubhw    <= u_b_h_w;
                        r_isWrite <= en_w;
                    end
                end
                CHECK: begin
                    if (!cache_hit) begin
                        r_beat <= '0;
                        if (cache_valid && cache_dirty) begin
                            r_victimTag <= cache_tag;
                        end
                    end
                end
                BACK_WR: begin
                    // The victim word is only on cache_dout in the first BACK_WR cycle.
                    if (!r_wbLatched) begin
                        r_wbData    <= cache_dout;
                        r_wbLatched <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        r_wbLatched <= 1'b0;
                        r_beat      <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_BITS'(1);
                    end
                end
                FILL: begin
                    if (mem_ack_i && (r_beat != LAST_BEAT)) begin
                        r_beat <= r_beat + BEAT_BITS'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_nextState   = r_state;
        stall         = 1'b0;
        data_cpu_read = '0;
        cache_addr    = '0;
        cache_load    = 1'b0;
        cache_edit    = 1'b0;
        cache_store   = 1'b0;
        cache_u_b_h_w = '0;
        cache_din     = '0;
        mem_cs_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    cache_addr    = addr_cpu;
                    cache_load    = ~en_w;
                    cache_edit    = en_w;
                    cache_u_b_h_w = u_b_h_w;
                    cache_din     = data_cpu_write;
                    stall         = 1'b1;
                    w_nextState   = CHECK;
                end
            end
            CHECK: begin
                if (cache_hit) begin
                    data_cpu_read = cache_dout;
                    w_nextState   = IDLE;
                end else begin
                    stall       = 1'b1;
                    w_nextState = (cache_valid && cache_dirty) ? BACK_RD : FILL;
                end
            end
            BACK_RD: begin
                stall         = 1'b1;
                cache_addr    = w_lineAddr;
                cache_u_b_h_w = r_ubhw;
                w_nextState   = BACK_WR;
            end
            BACK_WR: begin
                stall         = 1'b1;
                cache_addr    = w_lineAddr;
                cache_u_b_h_w = r_ubhw;
                mem_cs_o      = 1'b1;
                mem_we_o      = 1'b1;
                mem_addr_o    = w_victimAddr;
                mem_data_o    = r_wbLatched ? r_wbData : cache_dout;
                if (mem_ack_i) begin
                    w_nextState = (r_beat == LAST_BEAT) ? FILL : BACK_RD;
                end
            end
            FILL: begin
                stall         = 1'b1;
                cache_addr    = w_lineAddr;
                cache_u_b_h_w = r_ubhw;
                mem_cs_o      = 1'b1;
                mem_addr_o    = w_lineAddr;
                if (mem_ack_i) begin
                    cache_store = 1'b1;
                    cache_din   = mem_data_i;
                    w_nextState = (r_beat == LAST_BEAT) ? REPLAY : FILL;
                end
            end
            REPLAY: begin
                stall         = 1'b1;
                cache_addr    = r_addr;
                cache_load    = ~r_isWrite;
                cache_edit    = r_isWrite;
                cache_u_b_h_w = r_ubhw;
                cache_din     = r_data;
                w_nextState   = CHECK;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench: behavioural 2-way cache and memory around cache_ctrl, with CPU
// results compared against a flat architectural memory model.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_r;
    logic        en_w;
    logic [2:0]  u_b_h_w;
    logic [31:0] addr_cpu;
    logic [31:0] data_cpu_write;
    logic [31:0] data_cpu_read;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load;
    logic        cache_edit;
    logic        cache_store;
    logic [2:0]  cache_u_b_h_w;
    logic [31:0] cache_din;
    logic        cache_hit   = 1'b0;
    logic        cache_valid = 1'b0;
    logic        cache_dirty = 1'b0;
    logic [22:0] cache_tag   = '0;
    logic [31:0] cache_dout  = '0;
    logic        mem_cs_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i  = '0;
    logic        mem_ack_i   = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .u_b_h_w(u_b_h_w),
        .addr_cpu(addr_cpu), .data_cpu_write(data_cpu_write), .data_cpu_read(data_cpu_read),
        .stall(stall), .cache_addr(cache_addr), .cache_load(cache_load),
        .cache_edit(cache_edit), .cache_store(cache_store), .cache_u_b_h_w(cache_u_b_h_w),
        .cache_din(cache_din), .cache_hit(cache_hit), .cache_valid(cache_valid),
        .cache_dirty(cache_dirty), .cache_tag(cache_tag), .cache_dout(cache_dout),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] fmtLoad(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mergeStore(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off, input logic [31:0] d);
        logic [31:0] m;
        case (f3[1:0])
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        m = m << (8 * off);
        return (w & ~m) | ((d << (8 * off)) & m);
    endfunction

    logic [31:0] mainMem [logic [31:0]];
    logic [31:0] refMem  [logic [31:0]];

    function automatic logic [31:0] readMain(input logic [31:0] a);
        return mainMem.exists(a) ? mainMem[a] : initWord(a);
    endfunction

    function automatic logic [31:0] readRef(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    // Cache datapath stand-in: status and data are registered one cycle after the address.
    logic [22:0] cTagA   [2][32];
    logic        cValidA [2][32];
    logic        cDirtyA [2][32];
    logic [31:0] cDataA  [2][32][4];
    int          cLru    [32];

    initial begin
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 32; s++) begin
                cTagA[w][s] = '0;
                cValidA[w][s] = 1'b0;
                cDirtyA[w][s] = 1'b0;
                for (int k = 0; k < 4; k++) cDataA[w][s][k] = '0;
            end
        end
        for (int s = 0; s < 32; s++) cLru[s] = 0;
    end

    always @(posedge clk) begin
        int idx;
        int wd;
        int hw;
        int way;
        logic [22:0] tg;
        idx = int'(cache_addr[8:4]);
        wd  = int'(cache_addr[3:2]);
        tg  = cache_addr[31:9];
        hw  = -1;
        for (int w = 0; w < 2; w++) begin
            if (cValidA[w][idx] && (cTagA[w][idx] == tg)) hw = w;
        end
        if (cache_store) begin
            way = (hw >= 0) ? hw : cLru[idx];
            cTagA[way][idx]      = tg;
            cValidA[way][idx]    = 1'b1;
            cDirtyA[way][idx]    = 1'b0;
            cDataA[way][idx][wd] = cache_din;
        end else if (hw >= 0) begin
            cache_hit   <= 1'b1;
            cache_valid <= 1'b1;
            cache_dirty <= cDirtyA[hw][idx];
            cache_tag   <= tg;
            cache_dout  <= cache_load ? fmtLoad(cDataA[hw][idx][wd], cache_u_b_h_w, cache_addr[1:0])
                                      : cDataA[hw][idx][wd];
            if (cache_load || cache_edit) cLru[idx] = 1 - hw;
            if (cache_edit) begin
                cDataA[hw][idx][wd] = mergeStore(cDataA[hw][idx][wd], cache_u_b_h_w,
                                                 cache_addr[1:0], cache_din);
                cDirtyA[hw][idx] = 1'b1;
            end
        end else begin
            way = cLru[idx];
            cache_hit   <= 1'b0;
            cache_valid <= cValidA[way][idx];
            cache_dirty <= cDirtyA[way][idx];
            cache_tag   <= cTagA[way][idx];
            cache_dout  <= cDataA[way][idx][wd];
        end
    end

    int          memWait   = 0;
    int          curDelay  = 1;
    int          ackDelay  = 2;
    bit          randomAck = 1'b0;
    logic [31:0] wbAddrQ[$];
    logic [31:0] wbDataQ[$];

    // Main memory: one-cycle ack after ackDelay cycles of request; writes commit at the ack.
    always @(posedge clk) begin
        if (mem_ack_i || !mem_cs_o) begin
            mem_ack_i <= 1'b0;
            memWait = 0;
        end else begin
            if (memWait == 0) curDelay = randomAck ? int'($urandom_range(3, 1)) : ackDelay;
            memWait++;
            if (memWait >= curDelay) begin
                mem_ack_i <= 1'b1;
                if (mem_we_o) begin
                    mainMem[mem_addr_o] = mem_data_o;
                    wbAddrQ.push_back(mem_addr_o);
                    wbDataQ.push_back(mem_data_o);
                end else begin
                    mem_data_i <= readMain(mem_addr_o);
                end
            end
        end
    end

    logic idleLoad;
    logic idleEdit;

    function automatic logic [31:0] outputsOr();
        return data_cpu_read | cache_addr | cache_din | mem_addr_o | mem_data_o |
               {23'h0, stall, cache_load, cache_edit, cache_store, cache_u_b_h_w,
                mem_cs_o, mem_we_o};
    endfunction

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rdata, output int stallCycles);
        int guard;
        @(negedge clk);
        en_r = rd;
        en_w = wr;
        u_b_h_w = f3;
        addr_cpu = a;
        data_cpu_write = d;
        #1;
        idleLoad = cache_load;
        idleEdit = cache_edit;
        stallCycles = stall ? 1 : 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (stall) stallCycles++;
        end while (stall && (guard < 2000));
        if (stall) checkOutput("stallTimeout", 32'(stall), 32'h0);
        rdata = data_cpu_read;
        en_r = 1'b0;
        en_w = 1'b0;
    endtask

    task automatic doOp(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output int stallCycles);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        applyStimulus(rd, wr, f3, a, d, rdata, stallCycles);
        if (wr) refMem[wa] = mergeStore(readRef(wa), f3, a[1:0], d);
        else checkOutput(tag, rdata, fmtLoad(readRef(wa), f3, a[1:0]));
    endtask

    initial begin
        logic [31:0] rdata;
        int          sc;
        int          holdCount;
        int          guard;
        rst = 1'b1;
        en_r = 1'b0;
        en_w = 1'b0;
        u_b_h_w = '0;
        addr_cpu = '0;
        data_cpu_write = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", outputsOr(), 32'h0);
        rst = 1'b0;

        ackDelay = 2;
        doOp("coldRead10", 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, rdata, sc);
        checkOutput("coldMissStall", 32'(sc), 32'd15);
        doOp("hitRead14", 1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0, rdata, sc);
        checkOutput("hitStall", 32'(sc), 32'd1);
        doOp("sb12", 1'b0, 1'b1, 3'b000, 32'h0000_0012, 32'h0000_00AB, rdata, sc);
        checkOutput("writeHitStall", 32'(sc), 32'd1);
        doOp("lbu12", 1'b1, 1'b0, 3'b100, 32'h0000_0012, 32'h0, rdata, sc);
        checkOutput("lbu12Const", rdata, 32'h0000_00AB);
        doOp("sb13", 1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_0080, rdata, sc);
        doOp("lb13", 1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0, rdata, sc);
        checkOutput("lb13Const", rdata, 32'hFFFF_FF80);

        doOp("read210", 1'b1, 1'b0, 3'b010, 32'h0000_0210, 32'h0, rdata, sc);
        checkOutput("cleanMissStall", 32'(sc), 32'd15);
        wbAddrQ.delete();
        wbDataQ.delete();
        doOp("read410", 1'b1, 1'b0, 3'b010, 32'h0000_0410, 32'h0, rdata, sc);
        checkOutput("dirtyMissStall", 32'(sc), 32'd31);
        checkOutput("wbCount", 32'(wbAddrQ.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wbAddrQ.size()) begin
                checkOutput($sformatf("wbAddr%0d", i), wbAddrQ[i], 32'h10 + 32'(4 * i));
                checkOutput($sformatf("wbData%0d", i), wbDataQ[i], readRef(32'h10 + 32'(4 * i)));
            end
        end
        doOp("reread12", 1'b1, 1'b0, 3'b100, 32'h0000_0012, 32'h0, rdata, sc);
        checkOutput("reread12Const", rdata, 32'h0000_00AB);

        // Fill that never gets acked, aborted by reset.
        ackDelay = 1000;
        @(negedge clk);
        en_r = 1'b1;
        u_b_h_w = 3'b010;
        addr_cpu = 32'h0000_0020;
        guard = 0;
        while (!mem_cs_o && (guard < 20)) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("fillStart", 32'(mem_cs_o), 32'h1);
        holdCount = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_cs_o && (mem_addr_o == 32'h0000_0020) && !mem_we_o) holdCount++;
            @(negedge clk);
        end
        checkOutput("fillHold", 32'(holdCount), 32'd10);
        rst = 1'b1;
        en_r = 1'b0;
        @(negedge clk);
        checkOutput("midMissReset", outputsOr(), 32'h0);
        rst = 1'b0;
        ackDelay = 2;
        doOp("postResetHit", 1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0, rdata, sc);
        checkOutput("postResetStall", 32'(sc), 32'd1);

        doOp("bothEn", 1'b1, 1'b1, 3'b010, 32'h0000_0018, 32'hCAFE_BABE, rdata, sc);
        checkOutput("bothEnStrobes", {30'h0, idleEdit, idleLoad}, 32'h2);
        doOp("bothEnRead", 1'b1, 1'b0, 3'b010, 32'h0000_0018, 32'h0, rdata, sc);

        randomAck = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            logic        wr;
            logic [1:0]  off;
            wr = 1'($urandom_range(1, 0));
            if (wr) f3 = 3'($urandom_range(2, 0));
            else begin
                case ($urandom_range(4, 0))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            off = 2'($urandom_range(3, 0));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            a = (32'($urandom_range(3, 0)) << 9) | (($urandom_range(1, 0) != 0) ? 32'h30 : 32'h10) |
                (32'($urandom_range(3, 0)) << 2) | {30'h0, off};
            doOp($sformatf("rand%0d", i), ~wr, wr, f3, a, $urandom, rdata, sc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
